// File: rtl/spi_temp_responder_if.sv
// SPI link between an initiator and the temperature-sensor responder.
interface spi_temp_responder_if;
  logic sck;
  logic cs;
  logic mosi;
  logic miso;
  logic miso_oe;

  modport master (
    output sck,
    output cs,
    output mosi,
    input  miso,
    input  miso_oe
  );

  modport slave (
    input  sck,
    input  cs,
    input  mosi,
    output miso,
    output miso_oe
  );
endinterface

// File: rtl/spi_temp_responder.sv
// Mode-0 SPI responder emulating the temperature sensor register file (config, temp LSB/MSB).
// Optional SPI_TEMP_RESPONDER_STATUS_EN adds a read-only transaction counter at address 0x03.
module spi_temp_responder #(
  parameter bit          CS_ACTIVE = 1'b1,
  parameter logic [7:0]  CFG_RESET = 8'h00,
  parameter int unsigned TEMP_W    = 12
) (
  input  logic                sys_clk_pin,
  input  logic                rst_n,
  spi_temp_responder_if.slave spi,
  input  logic [TEMP_W-1:0]   temp_value,
  output logic [7:0]          cfg_reg,
  output logic                wr_strobe,
  output logic [6:0]          wr_addr,
  output logic [7:0]          wr_data,
  output logic                busy
);

  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned ADDR_W   = 7;
  localparam int unsigned CNT_W    = 3;
  localparam int unsigned TEMP_PAD = 16 - TEMP_W;

  localparam logic [ADDR_W-1:0] ADDR_CFG  = 7'h00;
  localparam logic [ADDR_W-1:0] ADDR_TLSB = 7'h01;
  localparam logic [ADDR_W-1:0] ADDR_TMSB = 7'h02;
`ifdef SPI_TEMP_RESPONDER_STATUS_EN
  localparam logic [ADDR_W-1:0] ADDR_STAT = 7'h03;
`endif

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA
  } state_t;

  // Two-flop synchronisers plus a delayed copy for edge detection.
  logic [1:0] sck_sync;
  logic [1:0] cs_sync;
  logic [1:0] mosi_sync;
  logic       sck_q;
  logic       cs_q;

  // cs is normalised to "active" here. Reset treats it as already active so a
  // transaction cut by reset is ignored until cs is seen inactive again.
  always_ff @(posedge sys_clk_pin) begin
    if (!rst_n) begin
      sck_sync  <= 2'b00;
      cs_sync   <= 2'b11;
      mosi_sync <= 2'b00;
      sck_q     <= 1'b0;
      cs_q      <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[0], spi.sck};
      cs_sync   <= {cs_sync[0], (spi.cs == CS_ACTIVE)};
      mosi_sync <= {mosi_sync[0], spi.mosi};
      sck_q     <= sck_sync[1];
      cs_q      <= cs_sync[1];
    end
  end

  logic cs_start;
  logic cs_stop;
  logic sck_rise;
  logic sck_fall;
  logic mosi_bit;

  assign cs_start = cs_sync[1] & ~cs_q;
  assign cs_stop  = ~cs_sync[1] & cs_q;
  assign sck_rise = sck_sync[1] & ~sck_q;
  assign sck_fall = ~sck_sync[1] & sck_q;
  assign mosi_bit = mosi_sync[1];

  state_t              state;
  logic [CNT_W-1:0]    bit_cnt;
  logic [BYTE_W-2:0]   in_sr;
  logic [BYTE_W-2:0]   out_sr;
  logic [ADDR_W-1:0]   addr;
  logic                wr_dir;
  logic [TEMP_W-1:0]   temp_snap;
`ifdef SPI_TEMP_RESPONDER_STATUS_EN
  logic [BYTE_W-1:0]   txn_cnt;
  logic                data_seen;
`endif

  logic [BYTE_W-1:0]   in_byte;
  logic                last_bit;
  logic [ADDR_W-1:0]   rd_addr;
  logic [BYTE_W-1:0]   rd_data;
  logic [15:0]         temp_aligned;

  assign in_byte      = {in_sr, mosi_bit};
  assign last_bit     = (bit_cnt == CNT_W'(BYTE_W - 1));
  assign temp_aligned = 16'(temp_snap) << TEMP_PAD;

  // Register that will be shifted out next: the start address at the end of
  // the address byte, otherwise the following address.
  always_comb begin
    rd_addr = (state == ST_ADDR) ? in_byte[ADDR_W-1:0] : addr + 7'd1;
    rd_data = 8'h00;
    case (rd_addr)
      ADDR_CFG:  rd_data = cfg_reg;
      ADDR_TLSB: rd_data = temp_aligned[7:0];
      ADDR_TMSB: rd_data = temp_aligned[15:8];
`ifdef SPI_TEMP_RESPONDER_STATUS_EN
      ADDR_STAT: rd_data = txn_cnt;
`endif
      default:   rd_data = 8'h00;
    endcase
  end

  // Transaction FSM. cs edges take priority over any sck edge on the same cycle.
  always_ff @(posedge sys_clk_pin) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      bit_cnt     <= '0;
      in_sr       <= '0;
      out_sr      <= '0;
      addr        <= '0;
      wr_dir      <= 1'b0;
      temp_snap   <= '0;
      cfg_reg     <= CFG_RESET;
      wr_strobe   <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      busy        <= 1'b0;
      spi.miso    <= 1'b0;
      spi.miso_oe <= 1'b0;
`ifdef SPI_TEMP_RESPONDER_STATUS_EN
      txn_cnt     <= '0;
      data_seen   <= 1'b0;
`endif
    end else begin
      wr_strobe <= 1'b0;
      if (cs_stop) begin
        state       <= ST_IDLE;
        busy        <= 1'b0;
        spi.miso    <= 1'b0;
        spi.miso_oe <= 1'b0;
        bit_cnt     <= '0;
        out_sr      <= '0;
`ifdef SPI_TEMP_RESPONDER_STATUS_EN
        if (data_seen) begin
          txn_cnt <= txn_cnt + 8'd1;
        end
        data_seen <= 1'b0;
`endif
      end else if (cs_start && (state == ST_IDLE)) begin
        state       <= ST_ADDR;
        temp_snap   <= temp_value;
        busy        <= 1'b1;
        spi.miso    <= 1'b0;
        spi.miso_oe <= 1'b1;
        bit_cnt     <= '0;
        in_sr       <= '0;
        out_sr      <= '0;
`ifdef SPI_TEMP_RESPONDER_STATUS_EN
        data_seen   <= 1'b0;
`endif
      end else if (state != ST_IDLE) begin
        if (sck_rise) begin
          in_sr   <= in_byte[BYTE_W-2:0];
          bit_cnt <= bit_cnt + CNT_W'(1);
          if (last_bit) begin
            if (state == ST_ADDR) begin
              state  <= ST_DATA;
              wr_dir <= in_byte[BYTE_W-1];
              addr   <= in_byte[ADDR_W-1:0];
              if (!in_byte[BYTE_W-1]) begin
                out_sr   <= rd_data[BYTE_W-2:0];
                spi.miso <= rd_data[BYTE_W-1];
              end
            end else begin
              addr <= addr + 7'd1;
`ifdef SPI_TEMP_RESPONDER_STATUS_EN
              data_seen <= 1'b1;
`endif
              if (wr_dir) begin
                if (addr == ADDR_CFG) begin
                  cfg_reg   <= in_byte;
                  wr_strobe <= 1'b1;
                  wr_addr   <= addr;
                  wr_data   <= in_byte;
                end
              end else begin
                out_sr   <= rd_data[BYTE_W-2:0];
                spi.miso <= rd_data[BYTE_W-1];
              end
            end
          end
        end else if (sck_fall && (bit_cnt != '0)) begin
          // The fall right after a byte boundary keeps the freshly loaded MSB.
          spi.miso <= out_sr[BYTE_W-2];
          out_sr   <= {out_sr[BYTE_W-3:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_temp_responder.sv
// Randomised mode-0 SPI initiator driving spi_temp_responder against a register-map reference model.
module tb_spi_temp_responder;

  localparam logic [7:0] CFG_RST = 8'h00;

  logic        sys_clk_pin;
  logic        rst_n;
  logic [11:0] temp_value;
  logic [7:0]  cfg_reg;
  logic        wr_strobe;
  logic [6:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        busy;

  spi_temp_responder_if bus ();

  spi_temp_responder #(
    .CS_ACTIVE (1'b1),
    .CFG_RESET (CFG_RST),
    .TEMP_W    (12)
  ) dut (
    .sys_clk_pin (sys_clk_pin),
    .rst_n       (rst_n),
    .spi         (bus.slave),
    .temp_value  (temp_value),
    .cfg_reg     (cfg_reg),
    .wr_strobe   (wr_strobe),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .busy        (busy)
  );

  initial sys_clk_pin = 1'b0;
  always #5 sys_clk_pin = ~sys_clk_pin;

  int n_cmp = 0;
  int n_err = 0;

  // Model state: register contents as the host should see them.
  logic [7:0] m_cfg = CFG_RST;
  logic [7:0] m_cnt = 8'h00;

  // Transaction description shared by the driver and the model.
  logic [7:0]  tx_buf [16];
  logic [7:0]  rx_buf [16];
  int          tx_len;
  int          tx_last_bits;
  int          chg_after;
  logic [11:0] chg_val;

  logic [14:0] wr_seen [$];

  always @(negedge sys_clk_pin) begin
    if (rst_n && wr_strobe) wr_seen.push_back({wr_addr, wr_data});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge sys_clk_pin);
  endtask

  // One byte (or a partial one), MSB first; miso is sampled just before each rise.
  task automatic spi_byte(input logic [7:0] tx, input int nbits, input int hp, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      bus.mosi = tx[7-i];
      wait_clk(hp);
      rx[7-i] = bus.miso;
      bus.sck = 1'b1;
      wait_clk(hp);
      bus.sck = 1'b0;
    end
  endtask

  task automatic run_txn(input int hp);
    int nb;
    wr_seen.delete();
    bus.cs = 1'b1;
    wait_clk(hp);
    for (int b = 0; b < tx_len; b++) begin
      nb = (b == tx_len - 1) ? tx_last_bits : 8;
      spi_byte(tx_buf[b], nb, hp, rx_buf[b]);
      if (b == 0) begin
        check("busy_active", 32'(busy), 32'd1);
        check("miso_oe_active", 32'(bus.miso_oe), 32'd1);
      end
      if (b == chg_after) temp_value = chg_val;
    end
    wait_clk(hp);
    bus.cs = 1'b0;
    wait_clk(8);
  endtask

  function automatic logic [7:0] model_read(input logic [6:0] a, input logic [11:0] t);
    case (a)
      7'h00: return m_cfg;
      7'h01: return {t[3:0], 4'h0};
      7'h02: return t[11:4];
`ifdef SPI_TEMP_RESPONDER_STATUS_EN
      7'h03: return m_cnt;
`endif
      default: return 8'h00;
    endcase
  endfunction

  // Walk the transaction byte by byte from the register-map rules.
  task automatic model_check(input logic [11:0] t0);
    int          full;
    logic [6:0]  a;
    logic        wr;
    logic [14:0] exp_wr [$];
    full = (tx_last_bits == 8) ? tx_len : tx_len - 1;
    a    = tx_buf[0][6:0];
    wr   = tx_buf[0][7];
    if (full >= 1) check("addr_byte_miso", 32'(rx_buf[0]), 32'h0);
    for (int k = 1; k < full; k++) begin
      if (!wr) check($sformatf("rd_a%0h", a), 32'(rx_buf[k]), 32'(model_read(a, t0)));
      else if (a == 7'h00) begin
        m_cfg = tx_buf[k];
        exp_wr.push_back({a, tx_buf[k]});
      end
      a = a + 7'd1;
    end
    if (full >= 2) m_cnt = m_cnt + 8'd1;
    check("wr_count", 32'(wr_seen.size()), 32'(exp_wr.size()));
    for (int k = 0; k < exp_wr.size(); k++) begin
      if (k < wr_seen.size()) check("wr_addr_data", 32'(wr_seen[k]), 32'(exp_wr[k]));
    end
    check("cfg_reg", 32'(cfg_reg), 32'(m_cfg));
    check("busy_idle", 32'(busy), 32'd0);
    check("miso_oe_idle", 32'(bus.miso_oe), 32'd0);
  endtask

  task automatic directed(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                          input int len, input int last_bits, input int hp);
    logic [11:0] t0;
    tx_buf[0] = b0; tx_buf[1] = b1; tx_buf[2] = b2;
    tx_len = len; tx_last_bits = last_bits;
    chg_after = 99; chg_val = 12'h000;
    t0 = temp_value;
    run_txn(hp);
    model_check(t0);
  endtask

  initial begin
    logic [7:0]  dummy;
    logic [6:0]  a;
    logic [11:0] t0;
    int          hp;
    int          sel;

    rst_n      = 1'b0;
    bus.sck    = 1'b0;
    bus.cs     = 1'b0;
    bus.mosi   = 1'b0;
    temp_value = 12'h000;
    wait_clk(5);
    check("rst_cfg", 32'(cfg_reg), 32'(CFG_RST));
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_miso", 32'(bus.miso), 32'd0);
    check("rst_miso_oe", 32'(bus.miso_oe), 32'd0);
    check("rst_wr_strobe", 32'(wr_strobe), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    rst_n = 1'b1;
    wait_clk(8);

    // Read config after reset, write config, read it back.
    directed(8'h00, 8'h00, 8'h00, 2, 8, 6);
    directed(8'h80, 8'h03, 8'h00, 2, 8, 5);
    directed(8'h00, 8'hA5, 8'h00, 2, 8, 4);

    // Temperature burst with a mid-burst change of the live input.
    temp_value = 12'h19A;
    tx_buf[0] = 8'h01; tx_buf[1] = 8'hFF; tx_buf[2] = 8'h00;
    tx_len = 3; tx_last_bits = 8; chg_after = 1; chg_val = 12'h000;
    run_txn(6);
    check("temp_lsb", 32'(rx_buf[1]), 32'hA0);
    check("temp_msb", 32'(rx_buf[2]), 32'h19);
    model_check(12'h19A);

    // Partial write byte is discarded.
    directed(8'h80, 8'hFF, 8'h00, 2, 5, 5);

    // Address wrap from 0x7F into config.
    directed(8'h80, 8'h55, 8'h00, 2, 8, 4);
    directed(8'h7F, 8'h12, 8'h34, 3, 8, 7);
    check("wrap_unmapped", 32'(rx_buf[1]), 32'h00);
    check("wrap_cfg", 32'(rx_buf[2]), 32'h55);

    // Reset in the middle of the data byte of a write.
    wr_seen.delete();
    hp = 5;
    bus.cs = 1'b1;
    wait_clk(hp);
    spi_byte(8'h80, 8, hp, dummy);
    spi_byte(8'hFF, 4, hp, dummy);
    rst_n = 1'b0;
    wait_clk(3);
    rst_n = 1'b1;
    m_cfg = CFG_RST;
    m_cnt = 8'h00;
    check("midrst_cfg", 32'(cfg_reg), 32'(CFG_RST));
    check("midrst_busy", 32'(busy), 32'd0);
    spi_byte(8'hF0, 4, hp, dummy);
    wait_clk(hp);
    bus.cs = 1'b0;
    wait_clk(8);
    check("midrst_no_write", 32'(wr_seen.size()), 32'd0);
    check("midrst_cfg_after", 32'(cfg_reg), 32'(CFG_RST));
    check("midrst_busy_after", 32'(busy), 32'd0);

    // Normal traffic afterwards, then read the status address.
    directed(8'h80, 8'hC3, 8'h00, 2, 8, 5);
    directed(8'h00, 8'h00, 8'h00, 2, 8, 5);
    temp_value = 12'h7E1;
    directed(8'h01, 8'h00, 8'h00, 3, 8, 6);
    directed(8'h03, 8'h00, 8'h00, 2, 8, 6);

    // Randomised transactions.
    for (int t = 0; t < 30; t++) begin
      hp  = $urandom_range(4, 7);
      sel = $urandom_range(0, 5);
      case (sel)
        0: a = 7'h00;
        1: a = 7'h01;
        2: a = 7'h02;
        3: a = 7'h03;
        4: a = 7'h7F;
        default: a = 7'($urandom_range(0, 127));
      endcase
      tx_len = 1 + $urandom_range(1, 3);
      tx_buf[0] = {($urandom_range(0, 2) == 0), a};
      for (int k = 1; k < tx_len; k++) tx_buf[k] = 8'($urandom_range(0, 255));
      tx_last_bits = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 7) : 8;
      temp_value = 12'($urandom_range(0, 4095));
      t0 = temp_value;
      chg_after = $urandom_range(0, tx_len - 1);
      chg_val = 12'($urandom_range(0, 4095));
      run_txn(hp);
      model_check(t0);
      wait_clk($urandom_range(1, 6));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
